// File: rtl/spram_arbiter_if.sv
// Requester-side bundle for one SPRAM arbiter port: request handshake plus read response.
// The requester drives the master modport; the arbiter takes the slave modport.
interface spram_arbiter_if;
    logic        valid;
    logic        ready;
    logic [3:0]  we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        rvalid;
    logic [15:0] rdata;

    modport master (
        output valid, we, addr, wdata,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  valid, we, addr, wdata,
        output ready, rvalid, rdata
    );
endinterface

// File: rtl/spram_arbiter.sv
// Purpose: two-port fixed-priority arbiter (p0 high, p1 starvation-guarded) in front of a 64Kx16 SPRAM.
// Latency: request accepted combinationally; read data returns exactly 1 cycle after accept.
// Backpressure: ready is low for the losing or idle port; read responses are never stalled.
// Optional: SPRAM_ARB_PERF_EN adds conflict/starvation counters with a synchronous clear.
module spram_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int WAIT_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    spram_arbiter_if.slave   p0,
    spram_arbiter_if.slave   p1,
    output logic [3:0]       mem_we,
    output logic [15:0]      mem_addr,
    output logic [15:0]      mem_wdata,
    input  logic [15:0]      mem_rdata
`ifdef SPRAM_ARB_PERF_EN
    ,
    input  logic             perf_clr,
    output logic [15:0]      perf_conflicts,
    output logic [15:0]      perf_starve
`endif
);

    localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_resp_vld;
    logic              r_resp_port;
    logic [15:0]       r_addr;
    logic [15:0]       r_wdata;

    logic              w_starve;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_rd_acc;
    logic [3:0]        w_gnt_we;
    logic [15:0]       w_gnt_addr;
    logic [15:0]       w_gnt_wdata;

    // Grants are gated by rst_n so ready and mem_we stay low for the whole reset window.
    always_comb begin
        w_starve    = rst_n && p1.valid && (r_wait_cnt == MAX_CNT);
        w_gnt1      = w_starve || (rst_n && p1.valid && !p0.valid);
        w_gnt0      = rst_n && p0.valid && !w_starve;
        w_gnt_we    = 4'h0;
        w_gnt_addr  = r_addr;
        w_gnt_wdata = r_wdata;
        if (w_gnt0) begin
            w_gnt_we    = p0.we;
            w_gnt_addr  = p0.addr;
            w_gnt_wdata = p0.wdata;
        end else if (w_gnt1) begin
            w_gnt_we    = p1.we;
            w_gnt_addr  = p1.addr;
            w_gnt_wdata = p1.wdata;
        end
        w_rd_acc = (w_gnt0 || w_gnt1) && (w_gnt_we == 4'h0);
    end

    assign p0.ready  = w_gnt0;
    assign p1.ready  = w_gnt1;
    assign mem_we    = w_gnt_we;
    assign mem_addr  = w_gnt_addr;
    assign mem_wdata = w_gnt_wdata;

    assign p0.rvalid = r_resp_vld && !r_resp_port;
    assign p1.rvalid = r_resp_vld &&  r_resp_port;
    assign p0.rdata  = mem_rdata;
    assign p1.rdata  = mem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt  <= '0;
            r_resp_vld  <= 1'b0;
            r_resp_port <= 1'b0;
            r_addr      <= 16'h0000;
            r_wdata     <= 16'h0000;
        end else begin
            if (!p1.valid || w_gnt1) begin
                r_wait_cnt <= '0;
            end else if (r_wait_cnt != MAX_CNT) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            r_resp_vld  <= w_rd_acc;
            r_resp_port <= w_gnt1;
            if (w_gnt0 || w_gnt1) begin
                r_addr  <= w_gnt_addr;
                r_wdata <= w_gnt_wdata;
            end
        end
    end

`ifdef SPRAM_ARB_PERF_EN
    logic [15:0] r_perf_conflicts;
    logic [15:0] r_perf_starve;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_conflicts <= 16'h0000;
            r_perf_starve    <= 16'h0000;
        end else if (perf_clr) begin
            r_perf_conflicts <= 16'h0000;
            r_perf_starve    <= 16'h0000;
        end else begin
            if (p0.valid && p1.valid && (r_perf_conflicts != 16'hFFFF)) begin
                r_perf_conflicts <= r_perf_conflicts + 16'h0001;
            end
            if (w_starve && (r_perf_starve != 16'hFFFF)) begin
                r_perf_starve <= r_perf_starve + 16'h0001;
            end
        end
    end

    assign perf_conflicts = r_perf_conflicts;
    assign perf_starve    = r_perf_starve;
`endif

endmodule

// File: tb/tb_spram_arbiter.sv
// Directed bench for spram_arbiter: a behavioural SPRAM array, queue scoreboard and monitor.
module tb_spram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
`ifdef SPRAM_ARB_PERF_EN
    logic        perf_clr = 1'b0;
    logic [15:0] perf_conflicts;
    logic [15:0] perf_starve;
`endif

    int checks = 0;
    int errors = 0;
    int p0_run = 0;
    int p0_max_run = 0;
    logic [15:0] exp0[$];
    logic [15:0] exp1[$];
    logic [15:0] mem_arr [0:65535];

    always #5 clk = ~clk;

    spram_arbiter_if p0 ();
    spram_arbiter_if p1 ();

    spram_arbiter #(.MAX_WAIT(4), .WAIT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .p0        (p0),
        .p1        (p1),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef SPRAM_ARB_PERF_EN
        ,
        .perf_clr       (perf_clr),
        .perf_conflicts (perf_conflicts),
        .perf_starve    (perf_starve)
`endif
    );

    // SPRAM array: nibble-masked write, registered read.
    always @(posedge clk) begin
        mem_rdata <= mem_arr[mem_addr];
        if (mem_we[0]) mem_arr[mem_addr][3:0]   <= mem_wdata[3:0];
        if (mem_we[1]) mem_arr[mem_addr][7:4]   <= mem_wdata[7:4];
        if (mem_we[2]) mem_arr[mem_addr][11:8]  <= mem_wdata[11:8];
        if (mem_we[3]) mem_arr[mem_addr][15:12] <= mem_wdata[15:12];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard whenever a response appears.
    always @(negedge clk) begin
        if (rst_n) begin
            if (p0.ready || p1.ready) check("ready_excl", {31'b0, p0.ready & p1.ready}, 32'h0);
            if (p0.rvalid && p1.rvalid) check("rvalid_excl", 32'h1, 32'h0);
            if (p0.rvalid) begin
                if (exp0.size() == 0) check("p0_unexpected_rvalid", 32'h1, 32'h0);
                else check("p0_rdata", {16'h0, p0.rdata}, {16'h0, exp0.pop_front()});
            end
            if (p1.rvalid) begin
                if (exp1.size() == 0) check("p1_unexpected_rvalid", 32'h1, 32'h0);
                else check("p1_rdata", {16'h0, p1.rdata}, {16'h0, exp1.pop_front()});
            end
            if (p0.rvalid) p0_run = p0_run + 1;
            else p0_run = 0;
            if (p0_run > p0_max_run) p0_max_run = p0_run;
        end
    end

    task automatic req(input int port, input logic [3:0] we, input logic [15:0] addr,
                       input logic [15:0] wdata, input logic [15:0] exp, output int waited);
        waited = 0;
        if (port == 0) begin
            p0.valid = 1'b1; p0.we = we; p0.addr = addr; p0.wdata = wdata;
        end else begin
            p1.valid = 1'b1; p1.we = we; p1.addr = addr; p1.wdata = wdata;
        end
        @(negedge clk);
        while ((((port == 0) ? p0.ready : p1.ready) == 1'b0) && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        if (waited >= 20) begin
            check("req_timeout", 32'h1, 32'h0);
        end else if (we == 4'h0) begin
            if (port == 0) exp0.push_back(exp);
            else exp1.push_back(exp);
        end
        @(posedge clk);
        #1;
        if (port == 0) p0.valid = 1'b0;
        else p1.valid = 1'b0;
    endtask

    initial begin
        int w;
        logic p1_win;
        p0.valid = 1'b0; p0.we = 4'h0; p0.addr = 16'h0; p0.wdata = 16'h0;
        p1.valid = 1'b0; p1.we = 4'h0; p1.addr = 16'h0; p1.wdata = 16'h0;

        // Reset state with both requesters active.
        p0.valid = 1'b1; p0.we = 4'hF; p0.addr = 16'h1111; p0.wdata = 16'h2222;
        p1.valid = 1'b1; p1.addr = 16'h3333;
        @(negedge clk);
        check("rst_mem_we", {28'h0, mem_we}, 32'h0);
        check("rst_p0_ready", {31'h0, p0.ready}, 32'h0);
        check("rst_p1_ready", {31'h0, p1.ready}, 32'h0);
        check("rst_rvalid", {30'h0, p0.rvalid, p1.rvalid}, 32'h0);
        check("rst_mem_addr", {16'h0, mem_addr}, 32'h0);
        check("rst_mem_wdata", {16'h0, mem_wdata}, 32'h0);
        @(posedge clk); #1;
        p0.valid = 1'b0; p1.valid = 1'b0; p0.we = 4'h0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Port 1 write then read back.
        req(1, 4'hF, 16'h4123, 16'hBEEF, 16'h0, w);
        check("t1_wr_wait", w, 0);
        req(1, 4'h0, 16'h4123, 16'h0, 16'hBEEF, w);
        check("t1_rd_wait", w, 0);
        @(negedge clk);
        check("t1_addr_hold", {16'h0, mem_addr}, 32'h4123);
        check("t1_idle_we", {28'h0, mem_we}, 32'h0);
        @(posedge clk); #1;

        // Partial nibble write merge, write-after-write then read-after-write.
        req(1, 4'hF, 16'hC000, 16'h1234, 16'h0, w);
        req(0, 4'h3, 16'hC000, 16'hABCD, 16'h0, w);
        req(0, 4'h0, 16'hC000, 16'h0, 16'h12CD, w);

        // All four banks, back-to-back reads.
        req(0, 4'hF, 16'h0001, 16'h0011, 16'h0, w);
        req(0, 4'hF, 16'h4001, 16'h0022, 16'h0, w);
        req(0, 4'hF, 16'h8001, 16'h0033, 16'h0, w);
        req(0, 4'hF, 16'hC001, 16'h0044, 16'h0, w);
        p0_max_run = 0;
        req(0, 4'h0, 16'h0001, 16'h0, 16'h0011, w);
        req(0, 4'h0, 16'h4001, 16'h0, 16'h0022, w);
        req(0, 4'h0, 16'h8001, 16'h0, 16'h0033, w);
        req(0, 4'h0, 16'hC001, 16'h0, 16'h0044, w);
        repeat (2) @(negedge clk);
        check("t4_consec_rvalid", p0_max_run, 4);
        @(posedge clk); #1;

`ifdef SPRAM_ARB_PERF_EN
        perf_clr = 1'b1;
        @(posedge clk); #1;
        perf_clr = 1'b0;
`endif
        // Dual readers: port 1 wins every fifth cycle.
        p0.valid = 1'b1; p0.we = 4'h0; p0.addr = 16'h0001;
        p1.valid = 1'b1; p1.we = 4'h0; p1.addr = 16'h4001;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            p1_win = ((i % 5) == 4);
            check("t2_p1_ready", {31'h0, p1.ready}, {31'h0, p1_win});
            check("t2_p0_ready", {31'h0, p0.ready}, {31'h0, !p1_win});
            if (p1.ready) exp1.push_back(16'h0022);
            if (p0.ready) exp0.push_back(16'h0011);
            @(posedge clk); #1;
        end
        p0.valid = 1'b0; p1.valid = 1'b0;
        @(negedge clk);
`ifdef SPRAM_ARB_PERF_EN
        check("perf_conflicts", {16'h0, perf_conflicts}, 32'd10);
        check("perf_starve", {16'h0, perf_starve}, 32'd2);
        @(posedge clk); #1;
        perf_clr = 1'b1;
        @(posedge clk); #1;
        perf_clr = 1'b0;
        @(negedge clk);
        check("perf_clr_conf", {16'h0, perf_conflicts}, 32'h0);
        check("perf_clr_starve", {16'h0, perf_starve}, 32'h0);
`endif
        @(posedge clk); #1;

        // Reset lands while a port 1 read response is due.
        p1.valid = 1'b1; p1.we = 4'h0; p1.addr = 16'h4123;
        @(negedge clk);
        check("t5_p1_accept", {31'h0, p1.ready}, 32'h1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        p0.valid = 1'b1; p0.we = 4'hF; p0.addr = 16'h4123; p0.wdata = 16'h0BAD;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("t5_rst_we", {28'h0, mem_we}, 32'h0);
            check("t5_rst_ready", {30'h0, p0.ready, p1.ready}, 32'h0);
            check("t5_rst_rvalid", {31'h0, p1.rvalid}, 32'h0);
        end
        @(posedge clk); #1;
        p0.valid = 1'b0; p1.valid = 1'b0; p0.we = 4'h0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_no_rvalid", {30'h0, p0.rvalid, p1.rvalid}, 32'h0);
        end
        @(posedge clk); #1;
        req(1, 4'h0, 16'h4123, 16'h0, 16'hBEEF, w);
        check("t5_post_rst_wait", w, 0);

        repeat (4) @(negedge clk);
        check("sb_drained", exp0.size() + exp1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
